io_channel_bank: RTL



---
 rtl/io_chan_pkg.sv | 24 ++
 rtl/io_channel_bank_if.sv | 21 ++
 rtl/chan_debounce.sv | 52 +++++
 rtl/io_channel_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/io_chan_pkg.sv
// io_chan_pkg: definitions shared by the channel I/O bank.
//   - chan_word_t    : one AGC channel word (bits 1-14 and 16; index 14 = bit 16)
//   - relay field    : select in [14:11], relay bits in [10:0]
//   - rly_state_e    : relay sequencer states
//   - DEF_*_BASE     : default channel base addresses (octal 10 and 30)
package io_chan_pkg;

  localparam int CHAN_WIDTH = 15;
  typedef logic [CHAN_WIDTH-1:0] chan_word_t;

  localparam int SEL_MSB  = 14;
  localparam int SEL_LSB  = 11;
  localparam int BITS_MSB = 10;
  localparam int BITS_LSB = 0;

  // Readback position of the sticky relay overrun flag on channel 0.
  localparam int OVRN_BIT = 12;

  localparam int DEF_OUT_BASE = 8;
  localparam int DEF_IN_BASE  = 24;

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} rly_state_e;

endpackage

// File: rtl/io_channel_bank_if.sv
// io_channel_bank_if: channel address/strobe bus between the CPU side and
// the channel bank.
//   CHADR  : channel address
//   WCHG   : write strobe      CCHG : clear strobe      RCHG : read strobe
//   CHWL_  : write data, active low
//   CHOR_  : read data, active low, idle all ones
// master = CPU side (drives strobes), slave = channel bank.
interface io_channel_bank_if #(
  parameter int AW    = 9,
  parameter int WIDTH = 15
);
  logic [AW-1:0]    CHADR;
  logic             WCHG;
  logic             CCHG;
  logic             RCHG;
  logic [WIDTH-1:0] CHWL_;
  logic [WIDTH-1:0] CHOR_;

  modport master (output CHADR, WCHG, CCHG, RCHG, CHWL_, input CHOR_);
  modport slave  (input CHADR, WCHG, CCHG, RCHG, CHWL_, output CHOR_);
endinterface

// File: rtl/chan_debounce.sv
// chan_debounce: debounces one WIDTH-bit input channel.
//   CLOCK, rst : clock and synchronous active-high reset
//   raw        : raw discretes, sampled every cycle
//   deb        : debounced word
//   chg        : one-cycle pulse, high while deb first shows a new value
// Each bit has its own counter; a bit flips only after DEBOUNCE consecutive
// samples that all differ from the current debounced value.
module chan_debounce #(
  parameter int WIDTH    = 15,
  parameter int DEBOUNCE = 3
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb,
  output logic             chg
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             chg_q, chg_d;

  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < WIDTH; b++) begin
      // A sample equal to the current value restarts the count.
      cnt_d[b] = '0;
      if (raw[b] != deb_q[b]) begin
        if (cnt_q[b] == CW'(DEBOUNCE - 1)) deb_d[b] = raw[b];
        else                               cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
    chg_d = (deb_d != deb_q);
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      deb_q <= '0;
      chg_q <= 1'b0;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
    end else begin
      deb_q <= deb_d;
      chg_q <= chg_d;
      for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign deb = deb_q;
  assign chg = chg_q;
endmodule

// File: rtl/io_channel_bank.sv
// io_channel_bank: N_OUT writable output channels and N_IN debounced input
// channels behind one channel address bus, plus the relay sequencer on
// output channel 0.
//   CLOCK, rst : clock and synchronous active-high reset
//   bus        : channel bus (slave): CHADR, WCHG, CCHG, RCHG, CHWL_, CHOR_
//   IN_DISC    : raw input discretes, channel k = slice k
//   OUT_CH     : output channel registers, channel k = slice k
//   RLYWD/RLYB : relay select / relay bits, driven during SETUP and HOLD
//   RLYSTB     : relay strobe, high for RELAY_HOLD cycles per word
//   RLY_BUSY   : sequencer active or a word pending
//   RLY_OVRN   : sticky, pending relay word was overwritten
//   IN_CHG     : per-input-channel change pulse
// Optional build macro CHAN_READBACK_EN: reads of output addresses return
// the inverted register (channel 0 also shows RLY_OVRN in bit 12);
// otherwise such reads return all ones.
module io_channel_bank
  import io_chan_pkg::*;
#(
  parameter int WIDTH      = 15,
  parameter int AW         = 9,
  parameter int N_OUT      = 2,
  parameter int OUT_BASE   = DEF_OUT_BASE,
  parameter int N_IN       = 4,
  parameter int IN_BASE    = DEF_IN_BASE,
  parameter int DEBOUNCE   = 3,
  parameter int RELAY_HOLD = 4
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  io_channel_bank_if.slave       bus,
  input  logic [N_IN*WIDTH-1:0]  IN_DISC,
  output logic [N_OUT*WIDTH-1:0] OUT_CH,
  output logic [3:0]             RLYWD,
  output logic [10:0]            RLYB,
  output logic                   RLYSTB,
  output logic                   RLY_BUSY,
  output logic                   RLY_OVRN,
  output logic [N_IN-1:0]        IN_CHG
);
  localparam int HW = (RELAY_HOLD > 1) ? $clog2(RELAY_HOLD) : 1;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] out_q [N_OUT];
  logic [WIDTH-1:0] out_d [N_OUT];
  logic [N_OUT-1:0] wr_hit, clr_hit;
  logic [WIDTH-1:0] deb [N_IN];

  assign wdata = ~bus.CHWL_;

  // Output registers: a write beats a clear in the same cycle.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign wr_hit[gi]  = bus.WCHG && (bus.CHADR == AW'(OUT_BASE + gi));
    assign clr_hit[gi] = bus.CCHG && (bus.CHADR == AW'(OUT_BASE + gi));
    assign out_d[gi]   = wr_hit[gi]  ? wdata :
                         clr_hit[gi] ? '0    : out_q[gi];
    assign OUT_CH[gi*WIDTH +: WIDTH] = out_q[gi];
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    chan_debounce #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_deb (
      .CLOCK (CLOCK),
      .rst   (rst),
      .raw   (IN_DISC[gi*WIDTH +: WIDTH]),
      .deb   (deb[gi]),
      .chg   (IN_CHG[gi])
    );
  end

  // Relay sequencer. A relay select of zero only updates the register.
  rly_state_e state_q, state_d;
  chan_word_t word_q, word_d, pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [HW-1:0] hold_q, hold_d;
  logic       ovrn_q, ovrn_d;
  logic [3:0] rlywd_q, rlywd_d;
  logic [10:0] rlyb_q, rlyb_d;
  logic       stb_q, stb_d, busy_q, busy_d;
  logic       launch;

  assign launch = wr_hit[0] && (wdata[SEL_MSB:SEL_LSB] != '0);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hold_d     = hold_q;
    ovrn_d     = clr_hit[0] ? 1'b0 : ovrn_q;
    case (state_q)
      IDLE:  if (launch) begin
               state_d = SETUP;
               word_d  = wdata[SEL_MSB:0];
             end
      SETUP: begin
               state_d = HOLD;
               hold_d  = '0;
             end
      HOLD:  if (hold_q == HW'(RELAY_HOLD - 1)) state_d = GAP;
             else                                hold_d  = hold_q + HW'(1);
      GAP:   if (pend_vld_q) begin
               state_d    = SETUP;
               word_d     = pend_q;
               pend_vld_d = 1'b0;
             end else begin
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
    // Checked after GAP has drained the buffer, so a launch landing in
    // that same cycle refills it without counting as an overrun.
    if (launch && state_q != IDLE) begin
      if (pend_vld_d) ovrn_d = 1'b1;
      pend_d     = wdata[SEL_MSB:0];
      pend_vld_d = 1'b1;
    end
    rlywd_d = '0;
    rlyb_d  = '0;
    if (state_d == SETUP || state_d == HOLD) begin
      rlywd_d = word_d[SEL_MSB:SEL_LSB];
      rlyb_d  = word_d[BITS_MSB:BITS_LSB];
    end
    stb_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  // Read path: one-cycle latency, all ones when nothing is addressed.
  logic [WIDTH-1:0] chor_q, chor_d;

  always_comb begin
    chor_d = '1;
    if (bus.RCHG) begin
      for (int k = 0; k < N_IN; k++)
        if (bus.CHADR == AW'(IN_BASE + k)) chor_d = ~deb[k];
`ifdef CHAN_READBACK_EN
      for (int k = 0; k < N_OUT; k++)
        if (bus.CHADR == AW'(OUT_BASE + k)) chor_d = ~out_q[k];
      if (bus.CHADR == AW'(OUT_BASE))
        chor_d[OVRN_BIT] = ~(out_q[0][OVRN_BIT] | ovrn_q);
`endif
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
      state_q    <= IDLE;
      word_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      hold_q     <= '0;
      ovrn_q     <= 1'b0;
      rlywd_q    <= '0;
      rlyb_q     <= '0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      chor_q     <= '1;
    end else begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
      state_q    <= state_d;
      word_q     <= word_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hold_q     <= hold_d;
      ovrn_q     <= ovrn_d;
      rlywd_q    <= rlywd_d;
      rlyb_q     <= rlyb_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
      chor_q     <= chor_d;
    end
  end

  assign bus.CHOR_ = chor_q;
  assign RLYWD     = rlywd_q;
  assign RLYB      = rlyb_q;
  assign RLYSTB    = stb_q;
  assign RLY_BUSY  = busy_q;
  assign RLY_OVRN  = ovrn_q;
endmodule
